// File: rtl/sample_packetizer.sv
// sample_packetizer
//   Frames a stream of 16-bit ADC samples into byte packets for the COBS
//   encoder: [PACKET_TYPE][seq][hi0][lo0]...[hiN-1][loN-1][xor checksum].
//   tlast marks the checksum byte so the encoder can delimit frames.
//
// Parameters
//   SAMPLES_PER_PACKET  samples per packet (1..64)
//   PACKET_TYPE         constant first byte of every packet
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   s_axis_tdata   16-bit sample in
//   s_axis_tvalid  sample valid
//   s_axis_tready  sample accepted when tvalid && tready
//   s_axis_tlast   unused
//   m_axis_tdata   packet byte out
//   m_axis_tvalid  byte valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   high on the checksum byte only
//   m_axis_tuser   tied 0
module sample_packetizer #(
  parameter int         SAMPLES_PER_PACKET = 8,
  parameter logic [7:0] PACKET_TYPE        = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser
);

  localparam logic [6:0] N_SAMPLES = 7'(SAMPLES_PER_PACKET);

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    SEQ,
    SAMPLE_HI,
    SAMPLE_LO,
    CHECK
  } state_t;

  state_t     r_state;
  logic [7:0] r_tdata;
  logic       r_tvalid;
  logic       r_tlast;
  logic [7:0] r_seq;
  logic [7:0] r_csum;
  logic [6:0] r_count;
  logic [7:0] r_lo;

  state_t     w_state_next;
  logic [7:0] w_tdata_next;
  logic       w_tvalid_next;
  logic       w_tlast_next;
  logic [7:0] w_seq_next;
  logic [7:0] w_csum_next;
  logic [6:0] w_count_next;
  logic [7:0] w_lo_next;

  logic       w_slot_free;
  logic       w_s_ready;
  logic       w_load;
  logic [7:0] w_load_byte;
  logic       w_load_last;
  logic       w_clear_csum;
  logic [6:0] w_count_inc;
  logic       w_unused;

  // The sample-side tlast carries no meaning for framing.
  assign w_unused = s_axis_tlast;

  // The single output slot can take a new byte when it is empty or its
  // current byte is handshaking this cycle.
  assign w_slot_free = !r_tvalid || m_axis_tready;
  assign w_count_inc = r_count + 7'd1;

  always_comb begin
    w_state_next  = r_state;
    w_s_ready     = 1'b0;
    w_load        = 1'b0;
    w_load_byte   = 8'h00;
    w_load_last   = 1'b0;
    w_clear_csum  = 1'b0;
    w_count_next  = r_count;
    w_lo_next     = r_lo;

    case (r_state)
      IDLE: begin
        // The checksum of the previous packet may still sit stalled in the
        // slot, so the type byte waits for it. When the checksum drains in
        // the same cycle the type byte follows with no gap.
        if (s_axis_tvalid && w_slot_free) begin
          w_load       = 1'b1;
          w_load_byte  = PACKET_TYPE;
          w_clear_csum = 1'b1;
          w_count_next = 7'd0;
          w_state_next = TYPE;
        end
      end
      TYPE: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_byte  = r_seq;
          w_state_next = SEQ;
        end
      end
      SEQ, SAMPLE_LO: begin
        w_s_ready = w_slot_free;
        if (w_slot_free && s_axis_tvalid) begin
          w_load       = 1'b1;
          w_load_byte  = s_axis_tdata[15:8];
          w_lo_next    = s_axis_tdata[7:0];
          w_state_next = SAMPLE_HI;
        end
      end
      SAMPLE_HI: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_byte  = r_lo;
          w_count_next = w_count_inc;
          w_state_next = (w_count_inc == N_SAMPLES) ? CHECK : SAMPLE_LO;
        end
      end
      CHECK: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_byte  = r_csum;
          w_load_last  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Slot: a handshaken byte empties the slot unless a new one loads.
    w_tdata_next  = r_tdata;
    w_tvalid_next = r_tvalid && !m_axis_tready;
    w_tlast_next  = (r_tvalid && !m_axis_tready) ? r_tlast : 1'b0;
    if (w_load) begin
      w_tdata_next  = w_load_byte;
      w_tvalid_next = 1'b1;
      w_tlast_next  = w_load_last;
    end

    // Running XOR restarts at the type byte; every loaded byte joins it.
    w_csum_next = (w_clear_csum ? 8'h00 : r_csum) ^ (w_load ? w_load_byte : 8'h00);

    // Sequence advances only once the checksum byte has actually left.
    w_seq_next = r_seq;
    if (r_tvalid && r_tlast && m_axis_tready) begin
      w_seq_next = r_seq + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_seq    <= 8'h00;
      r_csum   <= 8'h00;
      r_count  <= 7'd0;
      r_lo     <= 8'h00;
    end else begin
      r_state  <= w_state_next;
      r_tdata  <= w_tdata_next;
      r_tvalid <= w_tvalid_next;
      r_tlast  <= w_tlast_next;
      r_seq    <= w_seq_next;
      r_csum   <= w_csum_next;
      r_count  <= w_count_next;
      r_lo     <= w_lo_next;
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_sample_packetizer.sv
// Directed bench for sample_packetizer with N=2, PACKET_TYPE=0x01.
module tb_sample_packetizer;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] s_tdata = 16'h0000;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;

  logic        rand_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          drive_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_word = 9'h000;

  logic [8:0]  got_q[$];
  int          got_cyc[$];
  logic [8:0]  exp_q[$];

  sample_packetizer #(
    .SAMPLES_PER_PACKET(N),
    .PACKET_TYPE(8'h01)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready changes only just after the rising edge.
  always @(posedge clk) begin
    #1;
    m_tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor on the falling edge: a byte seen valid+ready here handshakes
  // at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_data", 32'({m_tlast, m_tdata}), 32'(prev_word));
      end
      if (s_tready) check("srdy_slot_free", 32'(!m_tvalid || m_tready), 32'd1);
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tdata});
        got_cyc.push_back(cyc);
        $display("byte %02h last=%0b cycle=%0d", m_tdata, m_tlast, cyc);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_word  = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Expected packet: type, seq, big-endian samples, XOR of all before it.
  task automatic push_packet(input logic [7:0] seq, input logic [15:0] a, input logic [15:0] b);
    logic [7:0] bytes[6];
    logic [7:0] x;
    bytes[0] = 8'h01; bytes[1] = seq;
    bytes[2] = a[15:8]; bytes[3] = a[7:0];
    bytes[4] = b[15:8]; bytes[5] = b[7:0];
    x = 8'h00;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, bytes[i]});
      x = x ^ bytes[i];
    end
    exp_q.push_back({1'b1, x});
  endtask

  task automatic send_sample(input logic [15:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("sample_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input logic check_gap);
    for (int t = 0; t < 20000 && got_q.size() < exp_q.size(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("stream_byte", 32'(got_q[i]), 32'(exp_q[i]));
      if (check_gap) check("no_gap", 32'(got_cyc[i] - got_cyc[0]), 32'(i));
    end
  endtask

  task automatic clear_streams();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_tdata"}, 32'(m_tdata), 32'd0);
    check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
    check({tag, "_tuser"}, 32'(m_tuser), 32'd0);
    check({tag, "_sready"}, 32'(s_tready), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_a");
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("rst_b");
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic found;

    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Two back-to-back packets at full throughput.
    @(posedge clk); #1;
    push_packet(8'h00, 16'h1234, 16'hABCD);
    push_packet(8'h01, 16'h1234, 16'hABCD);
    s_tdata   = 16'h1234;
    s_tvalid  = 1'b1;
    drive_cyc = cyc;
    send_sample(16'h1234);
    send_sample(16'hABCD);
    send_sample(16'h1234);
    send_sample(16'hABCD);
    s_tvalid = 1'b0;
    compare_stream(1'b1);
    if (got_cyc.size() > 0) check("type_latency", 32'(got_cyc[0] - drive_cyc), 32'd1);
    clear_streams();

    // Random downstream stalls.
    @(posedge clk); #1;
    rand_en = 1'b1;
    push_packet(8'h02, 16'h1234, 16'hABCD);
    send_sample(16'h1234);
    send_sample(16'hABCD);
    s_tvalid = 1'b0;
    compare_stream(1'b0);
    rand_en = 1'b0;
    clear_streams();

    // Source pauses for 10 cycles mid-packet.
    @(posedge clk); #1;
    push_packet(8'h03, 16'h1234, 16'hABCD);
    send_sample(16'h1234);
    s_tvalid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pause_tvalid", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    send_sample(16'hABCD);
    s_tvalid = 1'b0;
    compare_stream(1'b0);
    clear_streams();

    // Reset right after the 0x12 byte of a packet.
    @(posedge clk); #1;
    send_sample(16'h1234);
    s_tvalid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      foreach (got_q[i]) if (got_q[i][7:0] == 8'h12) found = 1'b1;
    end
    check("saw_0x12", 32'(found), 32'd1);
    do_reset();
    clear_streams();
    push_packet(8'h00, 16'h5555, 16'h0000);
    send_sample(16'h5555);
    send_sample(16'h0000);
    s_tvalid = 1'b0;
    compare_stream(1'b0);
    clear_streams();

    // 257 all-zero packets from a fresh reset: seq wraps to 0 on the last.
    do_reset();
    for (int p = 0; p < 257; p++) push_packet(8'(p), 16'h0000, 16'h0000);
    for (int i = 0; i < 257 * N; i++) send_sample(16'h0000);
    s_tvalid = 1'b0;
    compare_stream(1'b0);
    if (got_q.size() >= 257 * 7) begin
      check("wrap_seq", 32'(got_q[256 * 7 + 1]), 32'h000);
      check("wrap_csum", 32'(got_q[256 * 7 + 6]), 32'h101);
    end else begin
      check("wrap_len", 32'(got_q.size()), 32'(257 * 7));
    end
    clear_streams();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
